// File: rtl/mddr_init_refresh.sv
// -----------------------------------------------------------------------------
// mddr_init_refresh
//
// Mobile-DDR power-up initialisation sequencer and periodic auto-refresh
// generator. After reset it owns the SDRAM command bus. It runs the JEDEC
// power-up sequence: NOP wait, PRECHARGE-ALL, two REFRESH, LOAD MODE and
// LOAD EXTENDED MODE. It then hands the bus to the read/write arbiter and
// takes the bus back only to service refreshes it has been granted.
//
// Ports
//   clk_i        controller clock, all logic on the rising edge
//   rst_n_i      asynchronous active-low reset
//   ref_gnt_i    arbiter grant (banks idle, bus released to this block)
//   cke_o        SDRAM clock enable
//   cs_n_o, ras_n_o, cas_n_o, we_n_o   command strobes
//   a_o [12:0]   address
//   ba_o [1:0]   bank address
//   bus_own_o    this block drives the command bus
//   init_done_o  initialisation complete, sticky until reset
//   ref_req_o    at least one refresh interval expired and not yet serviced
// -----------------------------------------------------------------------------
module mddr_init_refresh #(
    parameter int          T_PWRUP_CYC  = 10000,
    parameter int          T_RP_CYC     = 2,
    parameter int          T_RFC_CYC    = 6,
    parameter int          T_MRD_CYC    = 2,
    parameter int          T_REFI_CYC   = 390,
    parameter logic [12:0] MODE_REG     = 13'h0032,
    parameter logic [12:0] EXT_MODE_REG = 13'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ref_gnt_i,
    output logic        cke_o,
    output logic        cs_n_o,
    output logic        ras_n_o,
    output logic        cas_n_o,
    output logic        we_n_o,
    output logic [12:0] a_o,
    output logic [1:0]  ba_o,
    output logic        bus_own_o,
    output logic        init_done_o,
    output logic        ref_req_o
);

    typedef enum logic [3:0] {
        S_PWRUP, S_PRE,  S_WRP,   S_REF1,  S_WRFC1, S_REF2, S_WRFC2, S_MRS,
        S_WMRD1, S_EMRS, S_WMRD2, S_IDLE,  S_RPRE,  S_RWRP, S_RREF,  S_RWRFC
    } state_t;

    // Command strobes {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // A gap state is entered one cycle after its command and must leave so
    // that the next command lands exactly T cycles after the previous one,
    // hence the "-2" loads. A spacing of 1 skips the gap state entirely.
    localparam logic [15:0] PWRUP_LOAD = 16'(T_PWRUP_CYC);
    localparam logic [15:0] RP_LOAD    = 16'(T_RP_CYC - 2);
    localparam logic [15:0] RFC_LOAD   = 16'(T_RFC_CYC - 2);
    localparam logic [15:0] MRD_LOAD   = 16'(T_MRD_CYC - 2);
    localparam logic [15:0] REFI_LOAD  = 16'(T_REFI_CYC - 1);
    localparam logic [3:0]  PEND_MAX   = 4'd8;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] refi_q;
    logic [3:0]  pend_q, pend_d;
    logic        ref_done;
    logic        expire;

    logic [3:0]  cmd_d;
    logic [12:0] a_d;
    logic [1:0]  ba_d;

    // -------------------------------------------------------------------------
    // Sequencer next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ref_done = 1'b0;
        unique case (state_q)
            S_PWRUP: begin
                if (wait_q == 16'd0) state_d = S_PRE;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_PRE: begin
                if (T_RP_CYC == 1) state_d = S_REF1;
                else begin state_d = S_WRP; wait_d = RP_LOAD; end
            end
            S_WRP: begin
                if (wait_q == 16'd0) state_d = S_REF1;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_REF1: begin
                if (T_RFC_CYC == 1) state_d = S_REF2;
                else begin state_d = S_WRFC1; wait_d = RFC_LOAD; end
            end
            S_WRFC1: begin
                if (wait_q == 16'd0) state_d = S_REF2;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_REF2: begin
                if (T_RFC_CYC == 1) state_d = S_MRS;
                else begin state_d = S_WRFC2; wait_d = RFC_LOAD; end
            end
            S_WRFC2: begin
                if (wait_q == 16'd0) state_d = S_MRS;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_MRS: begin
                if (T_MRD_CYC == 1) state_d = S_EMRS;
                else begin state_d = S_WMRD1; wait_d = MRD_LOAD; end
            end
            S_WMRD1: begin
                if (wait_q == 16'd0) state_d = S_EMRS;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_EMRS: begin
                if (T_MRD_CYC == 1) state_d = S_IDLE;
                else begin state_d = S_WMRD2; wait_d = MRD_LOAD; end
            end
            S_WMRD2: begin
                if (wait_q == 16'd0) state_d = S_IDLE;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_IDLE: begin
                // A grant is honoured only while a refresh is owed; one grant
                // buys exactly one refresh.
                if ((pend_q != 4'd0) && ref_gnt_i) state_d = S_RPRE;
            end
            S_RPRE: begin
                if (T_RP_CYC == 1) state_d = S_RREF;
                else begin state_d = S_RWRP; wait_d = RP_LOAD; end
            end
            S_RWRP: begin
                if (wait_q == 16'd0) state_d = S_RREF;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_RREF: begin
                if (T_RFC_CYC == 1) begin state_d = S_IDLE; ref_done = 1'b1; end
                else begin state_d = S_RWRFC; wait_d = RFC_LOAD; end
            end
            S_RWRFC: begin
                if (wait_q == 16'd0) begin state_d = S_IDLE; ref_done = 1'b1; end
                else                       wait_d  = wait_q - 16'd1;
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // -------------------------------------------------------------------------
    // Refresh bookkeeping: the interval timer free-runs once initialised and
    // never waits for service; pend remembers how many intervals are owed.
    // -------------------------------------------------------------------------
    assign expire = init_done_o && (refi_q == 16'd0);

    always_comb begin
        pend_d = pend_q;
        if (expire && !ref_done)
            pend_d = (pend_q == PEND_MAX) ? PEND_MAX : pend_q + 4'd1;
        else if (ref_done && !expire)
            pend_d = pend_q - 4'd1;
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs present
    // the command of the state being entered on this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_d = CMD_NOP;
        a_d   = 13'd0;
        ba_d  = 2'd0;
        unique case (state_d)
            S_PRE, S_RPRE: begin
                cmd_d = CMD_PRE;
                a_d   = 13'h0400;  // a[10]=1 selects all banks
            end
            S_REF1, S_REF2, S_RREF: cmd_d = CMD_REF;
            S_MRS: begin
                cmd_d = CMD_LMR;
                a_d   = MODE_REG;
            end
            S_EMRS: begin
                cmd_d = CMD_LMR;
                a_d   = EXT_MODE_REG;
                ba_d  = 2'b10;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_PWRUP;
            wait_q  <= PWRUP_LOAD;
            refi_q  <= 16'd0;
            pend_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            // The timer starts on the edge init_done_o rises.
            if (!init_done_o && (state_d == S_IDLE))
                refi_q <= REFI_LOAD;
            else if (init_done_o)
                refi_q <= expire ? REFI_LOAD : refi_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cke_o       <= 1'b0;
            cs_n_o      <= 1'b1;
            ras_n_o     <= 1'b1;
            cas_n_o     <= 1'b1;
            we_n_o      <= 1'b1;
            a_o         <= 13'd0;
            ba_o        <= 2'd0;
            bus_own_o   <= 1'b1;
            init_done_o <= 1'b0;
            ref_req_o   <= 1'b0;
        end else begin
            cke_o       <= 1'b1;
            {cs_n_o, ras_n_o, cas_n_o, we_n_o} <= cmd_d;
            a_o         <= a_d;
            ba_o        <= ba_d;
            bus_own_o   <= (state_d != S_IDLE);
            init_done_o <= init_done_o | (state_d == S_IDLE);
            ref_req_o   <= (pend_d != 4'd0);
        end
    end

endmodule

// File: doc/mddr_init_refresh.md
# mddr_init_refresh

Mobile-DDR power-up initialisation sequencer and periodic auto-refresh generator inside the mDDR controller of the BeMicro SoC. It sits directly upstream of the SDRAM command/address pins (a, ba, cke, cs_n, ras_n, cas_n, we_n). It owns the command bus during initialisation and during each refresh. It hands the bus to the read/write arbiter through a request/grant handshake.

## Interface
Parameters:
- T_PWRUP_CYC, 10000, power-up NOP interval in clocks (200 us at 50 MHz); 2..65535
- T_RP_CYC, 2, PRECHARGE-to-next-command spacing; ≥1
- T_RFC_CYC, 6, REFRESH-to-next-command spacing; ≥1
- T_MRD_CYC, 2, LOAD MODE-to-next-command spacing; ≥1
- T_REFI_CYC, 390, average refresh interval in clocks (7.8 us at 50 MHz); 2..65535
- MODE_REG, 13'h0032, mode register value (CL3, BL4, sequential)
- EXT_MODE_REG, 13'h0000, extended mode register value

Ports:
- clk_i  in  1  controller clock; all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- ref_gnt_i  in  1  arbiter grant: banks idle, bus released to this block
- cke_o  out  1  SDRAM clock enable
- cs_n_o, ras_n_o, cas_n_o, we_n_o  out  1 each  command strobes
- a_o  out  13  address
- ba_o  out  2  bank address
- bus_own_o  out  1  this block drives the command bus; arbiter muxes on this
- init_done_o  out  1  initialisation complete; sticky until reset
- ref_req_o  out  1  refresh pending

## Operation
- Command encodings (cs_n,ras_n,cas_n,we_n):
  - NOP = 0111
  - PRECHARGE-ALL = 0010 with a_o[10]=1
  - REFRESH = 0001
  - LOAD MODE = 0000
  - a_o/ba_o are 0 for every command except PRE-ALL and the two LOAD MODE commands.
- Every command is held for exactly one cycle. Spacing is counted command-to-command; the gap cycles are NOPs.
- Init FSM: PWRUP → PRE → WRP → REF1 → WRFC1 → REF2 → WRFC2 → MRS → WMRD1 → EMRS → WMRD2 → IDLE.
  - PWRUP: cke_o=1, NOP, for T_PWRUP_CYC cycles.
  - MRS: a_o=MODE_REG, ba_o=2'b00.
  - EMRS: a_o=EXT_MODE_REG, ba_o=2'b10.
- IDLE: bus_own_o=0, init_done_o=1, command outputs NOP, cke_o=1.
- Refresh FSM:
  - IDLE with pend≠0 and ref_gnt_i=1 → RPRE → RWRP → RREF → RWRFC → IDLE.
  - RPRE issues PRE-ALL; RREF issues REFRESH.
  - bus_own_o=1 in RPRE through RWRFC.
- Refresh interval counter (16 bit):
  - Starts on the cycle init_done_o rises and counts free-running.
  - Reloads on expiry, every T_REFI_CYC cycles, regardless of refresh service.
- pend (4-bit) counts expiries not yet serviced:
  - +1 on each expiry, saturating at 8.
  - −1 on the RWRFC → IDLE transition.
  - A simultaneous expiry and completion leaves it unchanged.
  - ref_req_o = (pend≠0).
- Grant rules:
  - ref_gnt_i is ignored before init_done_o and whenever pend=0.
  - Deassertion of ref_gnt_i mid-sequence is ignored; the sequence always completes.
  - One refresh is performed per grant. If pend is still nonzero after a refresh, a new grant is needed, sampled in IDLE.
- Reset asserted at any time: all outputs go to reset values immediately (asynchronously). The FSM returns to PWRUP and the full init sequence reruns after release.

## Timing
- All outputs are registered.
- Reset values: cke_o=0, cs_n_o=1, ras_n_o=1, cas_n_o=1, we_n_o=1, a_o=0, ba_o=0, bus_own_o=1, init_done_o=0, ref_req_o=0.
- Cycle 0 is the first rising edge with rst_n_i sampled high. Outputs change after edge n:
  - cke_o=1 and NOP from cycle 0.
  - PRE-ALL at cycle T_PWRUP_CYC.
  - REF at T_PWRUP_CYC+T_RP_CYC, then another REF T_RFC_CYC later.
  - MRS T_RFC_CYC after the second REF; EMRS T_MRD_CYC after MRS.
  - init_done_o=1 and bus_own_o=0 T_MRD_CYC after EMRS.
- Refresh latency: ref_gnt_i sampled high at edge k (in IDLE) → PRE-ALL at k+1 → REF at k+1+T_RP_CYC → bus_own_o falls at k+1+T_RP_CYC+T_RFC_CYC.
- The first ref_req_o rises T_REFI_CYC cycles after init_done_o.

## Test plan
Bench parameters: T_PWRUP_CYC=20, T_RP_CYC=2, T_RFC_CYC=6, T_MRD_CYC=2, T_REFI_CYC=50.
- Reset release, no grant → PRE-ALL (a_o[10]=1) at cycle 20, REF at 22 and 28, LOAD MODE a_o=13'h0032/ba_o=0 at 34, a_o=0/ba_o=2 at 36; init_done_o=1 and bus_own_o=0 at 38; NOP on every other cycle.
- Grant held high from cycle 0 → init timing identical to the first scenario; ref_req_o rises at 88; PRE-ALL at 89, REF at 91, bus_own_o=0 at 97, ref_req_o=0 at 97.
- Grant withheld for 500 cycles after init → pend saturates at 8; grant pulsed 8 times (1 cycle each, each pulse in IDLE) → exactly 8 REF commands, then ref_req_o=0 until the next expiry.
- Counter expiry on the same edge as an RWRFC → IDLE transition → pend unchanged, ref_req_o stays 1.
- ref_gnt_i dropped in RWRP → sequence completes; REF still issued 2 cycles after PRE-ALL.
- rst_n_i pulsed low during WRFC1 → cke_o=0, cs_n_o=1, bus_own_o=1 while low; after release, PRE-ALL again 20 cycles later.
